// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LOAD_USE, MEM_WAIT, HALTED} state_t;
  localparam logic [15:0] NOP_INSTR      = 16'hE000;
  localparam logic [3:0]  OPC_HLT        = 4'hF;
  localparam int          DEF_REG_ADDR_W = 4;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare; R0 is never a hazard source.
module load_use_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  output logic                  hz
);
  assign hz = mem_read && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: memory stall > load-use > taken branch > halt, Mealy outputs.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_rd,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rt,
  input  logic                  branch_taken,
  input  logic                  halt_id,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  output logic                  pc_write_en,
  output logic                  fd_enable,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic                  pipe_enable,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  state_t     state, nstate, ret_state, nret_state, eff;
  logic [1:0] cnt, ncnt;
  logic       hz, mem_stall;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .mem_read (de_mem_read),
    .rd       (de_rd),
    .rs       (fd_rs),
    .rt       (fd_rt),
    .uses_rt  (fd_uses_rt),
    .hz       (hz)
  );

  assign mem_stall = imem_stall || dmem_stall;
  assign halted    = rst && (state == HALTED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= nstate;
      ret_state <= nret_state;
      cnt       <= ncnt;
    end
  end

  always_comb begin
    pc_write_en = 1'b0;
    fd_enable   = 1'b0;
    fd_flush    = 1'b0;
    de_bubble   = 1'b0;
    pipe_enable = 1'b0;
    nstate      = state;
    nret_state  = ret_state;
    ncnt        = cnt;
    // MEM_WAIT behaves as the state it interrupted once memory is ready
    eff         = (state == MEM_WAIT) ? ret_state : state;
    if (!rst) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (state == HALTED) begin
      de_bubble   = 1'b1;
      pipe_enable = !mem_stall;
    end else if (mem_stall) begin
      nstate     = MEM_WAIT;
      nret_state = eff;
    end else begin
      unique case (eff)
        LOAD_USE: begin
          de_bubble   = 1'b1;
          pipe_enable = 1'b1;
          ncnt        = cnt - 2'd1;
          nstate      = (cnt == 2'd1) ? RUN : LOAD_USE;
        end
        default: begin
          nstate = RUN;
          if (hz) begin
            de_bubble   = 1'b1;
            pipe_enable = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              nstate = LOAD_USE;
              ncnt   = 2'(LOAD_USE_STALL - 1);
            end
          end else if (branch_taken) begin
            pc_write_en = 1'b1;
            fd_enable   = 1'b1;
            fd_flush    = 1'b1;
            pipe_enable = 1'b1;
          end else if (halt_id) begin
            de_bubble   = 1'b1;
            pipe_enable = 1'b1;
            nstate      = HALTED;
          end else begin
            pc_write_en = 1'b1;
            fd_enable   = 1'b1;
            pipe_enable = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write_en && !halted && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (fd_flush && !(&flush_q))                flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = rst ? stall_q : '0;
  assign flush_cnt = rst ? flush_q : '0;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a cycle-level reference model.
module tb_pipeline_hazard_controller;
  localparam int LUS = 2;
  localparam int RW  = 4;
  localparam int CW  = 16;
  localparam int AW  = 6 + 2*CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          de_mem_read, fd_uses_rt, branch_taken, halt_id, imem_stall, dmem_stall;
  logic [RW-1:0] de_rd, fd_rs, fd_rt;
  logic          pc_write_en, fd_enable, fd_flush, de_bubble, pipe_enable, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total  = 0;
  int passed = 0;

  // reference model: halted flag, remaining extra bubble cycles, event counts
  bit m_halted = 1'b0;
  int m_left   = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  pipeline_hazard_controller #(.LOAD_USE_STALL(LUS), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .de_mem_read(de_mem_read), .de_rd(de_rd), .fd_rs(fd_rs),
    .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt), .branch_taken(branch_taken), .halt_id(halt_id),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_write_en(pc_write_en),
    .fd_enable(fd_enable), .fd_flush(fd_flush), .de_bubble(de_bubble),
    .pipe_enable(pipe_enable), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_hz();
    return de_mem_read && (de_rd != 0) && ((de_rd == fd_rs) || (fd_uses_rt && (de_rd == fd_rt)));
  endfunction

  // {pc_write_en, fd_enable, fd_flush, de_bubble, pipe_enable, halted}
  function automatic logic [5:0] model_out();
    bit ms = imem_stall || dmem_stall;
    if (!rst)                  return 6'b001100;
    if (m_halted)              return {4'b0001, !ms, 1'b1};
    if (ms)                    return 6'b000000;
    if (m_left > 0 || model_hz()) return 6'b000110;
    if (branch_taken)          return 6'b111010;
    if (halt_id)               return 6'b000110;
    return 6'b110010;
  endfunction

  function automatic logic [AW-1:0] model_all();
    logic [CW-1:0] es = '0;
    logic [CW-1:0] ef = '0;
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      es = CW'(m_stall);
      ef = CW'(m_flush);
    end
`endif
    return {model_out(), es, ef};
  endfunction

  function automatic logic [AW-1:0] dut_all();
    return {pc_write_en, fd_enable, fd_flush, de_bubble, pipe_enable, halted, stall_cnt, flush_cnt};
  endfunction

  function automatic void model_advance();
    logic [5:0] e = model_out();
    if (!rst) begin
      m_halted = 1'b0;
      m_left   = 0;
      m_stall  = 0;
      m_flush  = 0;
      return;
    end
    if (!e[5] && !e[0] && m_stall < (1 << CW) - 1) m_stall++;
    if (e[3] && m_flush < (1 << CW) - 1)           m_flush++;
    if (m_halted || imem_stall || dmem_stall) return;
    if (m_left > 0)                           m_left--;
    else if (model_hz())                      m_left = LUS - 1;
    else if (!branch_taken && halt_id)        m_halted = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic quiet();
    de_mem_read = 0; de_rd = 0; fd_rs = 0; fd_rt = 0; fd_uses_rt = 0;
    branch_taken = 0; halt_id = 0; imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic rand_in();
    de_mem_read  = 1'($urandom_range(0, 1));
    de_rd        = RW'($urandom_range(0, 3));
    fd_rs        = RW'($urandom_range(0, 3));
    fd_rt        = RW'($urandom_range(0, 3));
    fd_uses_rt   = 1'($urandom_range(0, 1));
    branch_taken = ($urandom_range(0, 3) == 0);
    halt_id      = ($urandom_range(0, 39) == 0);
    imem_stall   = ($urandom_range(0, 7) == 0);
    dmem_stall   = ($urandom_range(0, 7) == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL reset_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      total++;
      if ({fd_flush, pc_write_en, halted} !== 3'b100)
        $display("FAIL reset_vals cyc%0d got %b exp 100", i, {fd_flush, pc_write_en, halted});
      else passed++;
      tick();
    end
    rst = 1'b1;
    quiet();
    @(negedge clk);
    total++;
    if (pc_write_en !== 1'b1) $display("FAIL reset_release pc_write_en got %b exp 1", pc_write_en);
    else passed++;
    tick();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      int st = 0;
      quiet();
      for (int i = 0; i < 5; i++) begin
        de_mem_read = (i < 2);
        de_rd       = (k == 0) ? RW'(3) : RW'(0);
        fd_rs       = RW'(3);
        @(negedge clk);
        total++;
        if (dut_all() !== model_all()) $display("FAIL load_use_model k%0d cyc%0d got %h exp %h", k, i, dut_all(), model_all());
        else passed++;
        if (!pc_write_en && de_bubble) st++;
        tick();
      end
      total++;
      if (st !== ((k == 0) ? LUS : 0)) $display("FAIL load_use_stalls k%0d got %0d exp %0d", k, st, (k == 0) ? LUS : 0);
      else passed++;
    end
  endtask

  task automatic test_branch_collision();
    int nfl = 0;
    int at  = -1;
    quiet();
    for (int i = 0; i < 4; i++) begin
      de_mem_read  = (i < 2);
      de_rd        = RW'(5);
      fd_rt        = RW'(5);
      fd_rs        = RW'(1);
      fd_uses_rt   = 1'b1;
      branch_taken = (i < 3);
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL branch_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      if (fd_flush) begin
        nfl++;
        at = i;
      end
      tick();
    end
    total++;
    if (nfl != 1 || at != LUS) $display("FAIL branch_flush got count %0d at %0d exp count 1 at %0d", nfl, at, LUS);
    else passed++;
  endtask

  task automatic test_mem_freeze();
    // {pc_write_en, fd_enable, pipe_enable, de_bubble}
    logic [3:0] tab [7] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b1110};
    quiet();
    for (int i = 0; i < 7; i++) begin
      de_mem_read = (i == 0);
      de_rd       = RW'(3);
      fd_rs       = RW'(3);
      dmem_stall  = (i >= 1 && i <= 4);
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL freeze_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      total++;
      if ({pc_write_en, fd_enable, pipe_enable, de_bubble} !== tab[i])
        $display("FAIL freeze_seq cyc%0d got %b exp %b", i, {pc_write_en, fd_enable, pipe_enable, de_bubble}, tab[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    quiet();
    halt_id = 1'b1;
    @(negedge clk);
    total++;
    if (dut_all() !== model_all()) $display("FAIL halt_entry got %h exp %h", dut_all(), model_all());
    else passed++;
    tick();
    for (int i = 0; i < 20; i++) begin
      rand_in();
      imem_stall = 1'b0;
      dmem_stall = 1'b0;
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL halt_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      if (!halted || pc_write_en || !pipe_enable) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL halt_hold bad cycles got %0d exp 0", bad);
    else passed++;
    dmem_stall = 1'b1;
    @(negedge clk);
    total++;
    if ({halted, pipe_enable} !== 2'b10) $display("FAIL halt_memstall got %b exp 10", {halted, pipe_enable});
    else passed++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (halted !== 1'b0) $display("FAIL halt_reset halted got %b exp 0", halted);
    else passed++;
    tick();
    rst = 1'b1;
    quiet();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      rand_in();
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL random_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      tick();
    end
    rst = 1'b1;
  endtask

  task automatic test_perf_cnt();
    logic [2*CW-1:0] exp_c;
    quiet();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_stall   = (i < 3);
      branch_taken = (i == 3 || i == 4);
      @(negedge clk);
      total++;
      if (dut_all() !== model_all()) $display("FAIL perf_model cyc%0d got %h exp %h", i, dut_all(), model_all());
      else passed++;
      tick();
    end
    quiet();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    exp_c = {CW'(3), CW'(2)};
`else
    exp_c = '0;
`endif
    total++;
    if ({stall_cnt, flush_cnt} !== exp_c)
      $display("FAIL perf_counts got stall %0d flush %0d exp %0d/%0d", stall_cnt, flush_cnt, exp_c[2*CW-1:CW], exp_c[CW-1:0]);
    else passed++;
    tick();
  endtask

  initial begin
    quiet();
    test_reset();
    test_load_use();
    test_branch_collision();
    test_mem_freeze();
    test_halt();
    test_random();
    test_perf_cnt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
